signal_creator_2: RTL and testbench
===================================

# signal_creator_2

Serial pattern generator built on a circular (ring) shift register. A WIDTH-bit pattern is parallel-loaded from `D`, then rotated one position per clock so that `out` repeats the pattern bit-serially and indefinitely. It is a leaf block in the synchronous sequential circuits group and produces test or timing waveforms for downstream logic.

## Interface
- `WIDTH`, default 4: pattern length in bits; minimum 2.
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `load`, input, 1: mode select, active-low load.
  - 0 = parallel load.
  - 1 = rotate.
- `D`, input, [0:WIDTH-1]: parallel pattern. Ascending bit order; `D[0]` is emitted first.
- `out`, output, 1: registered serial pattern bit.
- `sync`, output, 1: registered frame marker. Present only with `SIGNAL_CREATOR_SYNC_EN` (see Configuration).

## Operation
- Internal state:
  - `sr[0:WIDTH-1]` pattern register.
  - `pos`, a ceil(log2(WIDTH))-bit phase counter.
- `out` is always `sr[0]`, with no combinational path from inputs.
- Reset (`rst`=1, any time, asynchronous):
  - `sr` <= all 0, `pos` <= 0.
  - `out` = 0, `sync` = 0.
  - These values hold while `rst` is asserted.
- Load (`load`=0 at a rising edge):
  - `sr` <= `D`, `pos` <= 0.
  - `out` becomes `D[0]`.
- Rotate (`load`=1 at a rising edge):
  - `sr[i]` <= `sr[i+1]` for i < WIDTH-1, and `sr[WIDTH-1]` <= `sr[0]`.
  - `pos` <= `pos`+1, wrapping from WIDTH-1 to 0.
- Output sequence after a load: `D[0], D[1], …, D[WIDTH-1], D[0], …`, with period WIDTH cycles.
- Rotating without a prior load after reset circulates all zeros; `out` stays 0.
- Reload mid-sequence: the pattern restarts from `D[0]` at that edge. The remaining bits of the old frame are discarded.
- `D` is sampled only on load edges. Changes to `D` while rotating have no effect.
- All-zero and all-one patterns are legal and give a constant `out`.

## Timing
- Load latency: `out` = `D[0]` immediately after the load edge (1 cycle from `load`=0 setup to visible output).
- Each rotate edge advances `out` by exactly one pattern bit.
- `rst` deassertion is synchronized by the user. The first edge after deassertion is a normal load or rotate edge.
- `rst` asserted simultaneously with a clock edge: reset wins.
- `load` and `D` must meet setup/hold to `clk`. There is no handshake; the block is always active.

## Configuration
- Macro: `SIGNAL_CREATOR_SYNC_EN`.
- Defined:
  - `sync` port exists.
  - `sync` = 1 whenever `pos` = 0 and at least one load has occurred since reset, i.e. the cycle in which `out` carries `D[0]`. Otherwise `sync` = 0.
  - Requires a 1-bit "loaded" flag, cleared by reset and set on load.
- Not defined:
  - No `sync` port, no loaded flag.
  - `pos` may be removed; `out` behaviour is identical.

## Test plan
- Reset: assert `rst` mid-rotation with pattern 1001 loaded -> `out`=0 immediately, before the next edge. After deassert with `load`=1, `out` stays 0 for 8 edges.
- Load and rotate, WIDTH=4, `D`=1001:
  - One edge with `load`=0, then 8 edges with `load`=1.
  - `out` after each edge = 1, 0, 0, 1, 1, 0, 0, 1, 1.
- Reload mid-frame:
  - Load 1001, rotate 2 edges (`out`=0), then load 0110 -> `out`=0.
  - Then rotating -> 1, 1, 0, 0, 1, …
- `D` change during rotate: load 1001, then drive `D`=1111 with `load`=1 -> sequence stays 0, 0, 1, 1, 0, 0, 1.
- Sync (macro defined): load 1001 and rotate 8 edges -> `sync`=1 after the load edge and after rotate edges 4 and 8 only. `sync` stays 0 after reset until the first load.
- Held load: `load`=0 for 3 consecutive edges with `D`=1001 -> `out` stays 1 (`D[0]`) and `pos` stays 0.

Source files
------------

// File: rtl/signal_creator_2.sv
// signal_creator_2: ring-shift serial pattern generator, D[0] emitted first after a load.
// Optional frame marker output sync is enabled by defining SIGNAL_CREATOR_SYNC_EN.
module signal_creator_2 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [0:WIDTH-1] D,
`ifdef SIGNAL_CREATOR_SYNC_EN
   output logic             sync,
`endif
   output logic             out
);
   logic [0:WIDTH-1] r_sr;
   logic [0:WIDTH-1] w_sr_nxt;
   assign w_sr_nxt = load ? {r_sr[1:WIDTH-1], r_sr[0]} : D;
   assign out = r_sr[0];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sr <= '0;
      else r_sr <= w_sr_nxt;
   end
`ifdef SIGNAL_CREATOR_SYNC_EN
   localparam int PW = $clog2(WIDTH);
   logic [PW-1:0] r_pos;
   logic [PW-1:0] w_pos_nxt;
   logic          r_loaded;
   logic          r_sync;
   assign w_pos_nxt = !load ? '0 : (r_pos == PW'(WIDTH - 1)) ? '0 : r_pos + 1'b1;
   assign sync = r_sync;
   // sync is registered from next-state so it aligns with the cycle out carries D[0]
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pos    <= '0;
         r_loaded <= 1'b0;
         r_sync   <= 1'b0;
      end else begin
         r_pos    <= w_pos_nxt;
         r_loaded <= r_loaded | ~load;
         r_sync   <= (w_pos_nxt == '0) & (r_loaded | ~load);
      end
   end
`endif
endmodule

// File: tb/tb_signal_creator_2.sv
// tb_signal_creator_2: directed and randomized checks of signal_creator_2 against a pattern/phase model.
module tb_signal_creator_2;
   localparam int WIDTH = 4;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             load = 1'b1;
   logic [0:WIDTH-1] D = '0;
   logic             out;
`ifdef SIGNAL_CREATOR_SYNC_EN
   logic             sync;
`endif
   int n_chk = 0;
   int n_pass = 0;
   logic [0:WIDTH-1] m_pat = '0;
   int               m_ph = 0;
   bit               m_loaded = 1'b0;

   signal_creator_2 #(.WIDTH(WIDTH)) dut (
      .clk(clk),
      .rst(rst),
      .load(load),
      .D(D),
`ifdef SIGNAL_CREATOR_SYNC_EN
      .sync(sync),
`endif
      .out(out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_pat = '0;
      m_ph = 0;
      m_loaded = 1'b0;
   endtask

   task automatic check_outs(input string tag);
      check({tag, ".out"}, {31'd0, out}, {31'd0, m_pat[m_ph]});
`ifdef SIGNAL_CREATOR_SYNC_EN
      check({tag, ".sync"}, {31'd0, sync}, {31'd0, m_loaded && m_ph == 0});
`endif
   endtask

   task automatic step(input logic ld, input logic [0:WIDTH-1] d, input string tag);
      load = ld;
      D = d;
      @(posedge clk);
      #1;
      if (!ld) begin
         m_pat = d;
         m_ph = 0;
         m_loaded = 1'b1;
      end else m_ph = (m_ph + 1) % WIDTH;
      check_outs(tag);
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outs(tag);
      #1 rst = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset");
      rst = 1'b0;
      model_reset();
      step(1'b0, 4'b1001, "ld1001");
      for (int i = 0; i < 8; i++) step(1'b1, 4'b1001, "rot1001");
      step(1'b1, 4'b0000, "rot_mid");
      async_reset("async_rst");
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_outs("rst_held");
      rst = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b1, 4'b1111, "rot_zero");
      step(1'b0, 4'b1001, "reld_a");
      step(1'b1, 4'b1001, "reld_r1");
      step(1'b1, 4'b1001, "reld_r2");
      step(1'b0, 4'b0110, "reld_b");
      for (int i = 0; i < 5; i++) step(1'b1, 4'b0110, "reld_rot");
      step(1'b0, 4'b1001, "dchg_ld");
      for (int i = 0; i < 7; i++) step(1'b1, 4'b1111, "dchg_rot");
      for (int i = 0; i < 3; i++) step(1'b0, 4'b1001, "held_ld");
      step(1'b0, 4'b1111, "all_one");
      for (int i = 0; i < 5; i++) step(1'b1, 4'b0000, "all_one_r");
      step(1'b0, 4'b0000, "all_zero");
      for (int i = 0; i < 5; i++) step(1'b1, 4'b1111, "all_zero_r");
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) async_reset("rnd_rst");
         step(($urandom_range(0, 4) != 0), WIDTH'($urandom), "rnd");
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
